// File: rtl/lsu_pkg.sv
// lsu_pkg: shared opcode/func3 encodings, LSU FSM states and timeout default.
package lsu_pkg;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_L  = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;

    localparam logic [2:0] LB_func3  = 3'b000;
    localparam logic [2:0] LH_func3  = 3'b001;
    localparam logic [2:0] LW_func3  = 3'b010;
    localparam logic [2:0] LBU_func3 = 3'b100;
    localparam logic [2:0] LHU_func3 = 3'b101;
    localparam logic [2:0] SB_func3  = 3'b000;
    localparam logic [2:0] SH_func3  = 3'b001;
    localparam logic [2:0] SW_func3  = 3'b010;

    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic {IDLE, ACCESS} lsu_state_t;
endpackage

// File: rtl/lsu_stage_load_extend.sv
// load_extend: selects the addressed byte/halfword of a read word and sign/zero-extends it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata[{addr, 3'b000} +: 8];
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        data = func3 == LB_func3  ? {{24{b[7]}}, b}  :
               func3 == LBU_func3 ? {24'd0, b}       :
               func3 == LH_func3  ? {{16{h[15]}}, h} :
               func3 == LHU_func3 ? {16'd0, h}       : rdata;
    end
endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: load/store handshake and registered writeback staging after the ALU.
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic        bus_err
);
    lsu_state_t state, state_n;
    logic [7:0]  cnt, cnt_n, cnt_inc;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q, a;
    logic [4:0]  rd_q, wb_rd_n;
    logic [31:0] ext, wb_data_n, wd;
    logic [3:0]  strb;
    logic        accept, is_ld, is_st, is_alu, f3_ok, aligned, start;
    logic        wb_valid_n, misalign_n, bus_err_n;

    load_extend u_ext (.func3(f3_q), .addr(lo_q), .rdata(mem_rdata), .data(ext));

    assign ex_ready = state == IDLE;
    assign mem_req  = state == ACCESS;

    always_comb begin
        a       = alu_out[1:0];
        accept  = ex_valid && ex_ready;
        is_ld   = opcode == OP_L;
        is_st   = opcode == OP_S;
        is_alu  = opcode == OP_I || opcode == OP_R || opcode == LUI || opcode == AUIPC ||
                  opcode == JAL || opcode == JALR;
        f3_ok   = is_ld ? (func3 == LB_func3 || func3 == LH_func3 || func3 == LW_func3 ||
                           func3 == LBU_func3 || func3 == LHU_func3) :
                          (func3 == SB_func3 || func3 == SH_func3 || func3 == SW_func3);
        aligned = func3[1:0] == 2'b10 ? a == 2'b00 : func3[1:0] == 2'b01 ? !a[0] : 1'b1;
        start   = accept && (is_ld || is_st) && f3_ok && aligned;
        strb    = func3 == SB_func3 ? 4'b0001 << a :
                  func3 == SH_func3 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
        wd      = func3 == SB_func3 ? {4{store_data[7:0]}} :
                  func3 == SH_func3 ? {2{store_data[15:0]}} : store_data;
        cnt_inc = cnt + 8'd1;
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        wb_valid_n = 1'b0;
        wb_rd_n    = wb_rd;
        wb_data_n  = wb_data;
        misalign_n = 1'b0;
        bus_err_n  = 1'b0;
        if (state == IDLE) begin
            if (accept && is_alu) begin
                wb_valid_n = 1'b1;
                wb_rd_n    = rd;
                wb_data_n  = alu_out;
            end
            misalign_n = accept && (is_ld || is_st) && f3_ok && !aligned;
            state_n    = start ? ACCESS : IDLE;
            cnt_n      = 8'd0;
        end else if (mem_ack) begin
            // ack wins over a timeout reached in the same cycle
            state_n    = IDLE;
            cnt_n      = 8'd0;
            wb_valid_n = !mem_we;
            wb_rd_n    = mem_we ? wb_rd : rd_q;
            wb_data_n  = mem_we ? wb_data : ext;
        end else if (cnt_inc == 8'(TIMEOUT_CYCLES)) begin
            state_n   = IDLE;
            cnt_n     = 8'd0;
            bus_err_n = 1'b1;
        end else begin
            cnt_n = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 30'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
            f3_q      <= 3'd0;
            lo_q      <= 2'd0;
            rd_q      <= 5'd0;
            wb_valid  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'd0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            wb_valid <= wb_valid_n;
            wb_rd    <= wb_rd_n;
            wb_data  <= wb_data_n;
            misalign <= misalign_n;
            bus_err  <= bus_err_n;
            if (start) begin
                mem_we    <= is_st;
                mem_addr  <= alu_out[31:2];
                mem_wdata <= wd;
                mem_wstrb <= is_st ? strb : 4'd0;
                f3_q      <= func3;
                lo_q      <= a;
                rd_q      <= rd;
            end
        end
    end
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed-vector bench for lsu_stage with immediate-assertion checks.
module tb_lsu_stage;
    import lsu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_ready;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] alu_out = 32'd0, store_data = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata = 32'd0;
    logic [3:0]  mem_wstrb;
    logic        wb_valid, misalign, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    int checks = 0, errors = 0;
    int n;

    lsu_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .opcode(opcode), .func3(func3), .alu_out(alu_out), .store_data(store_data), .rd(rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] r);
        ex_valid = 1'b1; opcode = op; func3 = f3; alu_out = addr; store_data = sd; rd = r;
    endtask

    initial begin
        #2;
        chk("rst ex_ready", 32'(ex_ready), 1);
        chk("rst mem_req", 32'(mem_req), 0);
        chk("rst wb_valid", 32'(wb_valid), 0);
        chk("rst wb_data", wb_data, 0);
        chk("rst mem_wstrb", 32'(mem_wstrb), 0);
        @(negedge clk) rst_n = 1'b1;

        // ALU result writeback
        issue(OP_R, 3'd0, 32'h5, 32'd0, 5'd3);
        @(negedge clk) ex_valid = 1'b0;
        chk("opr wb_valid", 32'(wb_valid), 1);
        chk("opr wb_rd", 32'(wb_rd), 3);
        chk("opr wb_data", wb_data, 32'h5);
        chk("opr mem_req", 32'(mem_req), 0);
        @(negedge clk);
        chk("opr wb single", 32'(wb_valid), 0);

        // branch: nothing happens
        issue(OP_B, 3'd0, 32'h44, 32'd0, 5'd7);
        @(negedge clk) ex_valid = 1'b0;
        chk("opb wb_valid", 32'(wb_valid), 0);
        chk("opb mem_req", 32'(mem_req), 0);

        // SB lanes
        issue(OP_S, SB_func3, 32'h102, 32'h1234_56A5, 5'd1);
        @(negedge clk) ex_valid = 1'b0;
        chk("sb mem_req", 32'(mem_req), 1);
        chk("sb mem_we", 32'(mem_we), 1);
        chk("sb mem_addr", 32'(mem_addr), 32'h40);
        chk("sb mem_wstrb", 32'(mem_wstrb), 32'b0100);
        chk("sb mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("sb ex_ready", 32'(ex_ready), 0);
        mem_ack = 1'b1;
        @(negedge clk) mem_ack = 1'b0;
        chk("sb done mem_req", 32'(mem_req), 0);
        chk("sb no wb", 32'(wb_valid), 0);
        chk("sb ex_ready", 32'(ex_ready), 1);

        // SH upper half
        issue(OP_S, SH_func3, 32'h206, 32'h0000_BEEF, 5'd1);
        @(negedge clk) ex_valid = 1'b0;
        chk("sh mem_wstrb", 32'(mem_wstrb), 32'b1100);
        chk("sh mem_wdata", mem_wdata, 32'hBEEF_BEEF);
        mem_ack = 1'b1;
        @(negedge clk) mem_ack = 1'b0;

        // LB with 3 wait cycles
        issue(OP_L, LB_func3, 32'h203, 32'd0, 5'd9);
        @(negedge clk) ex_valid = 1'b0;
        chk("lb mem_req", 32'(mem_req), 1);
        chk("lb mem_we", 32'(mem_we), 0);
        chk("lb mem_wstrb", 32'(mem_wstrb), 0);
        chk("lb mem_addr", 32'(mem_addr), 32'h80);
        repeat (3) @(negedge clk);
        chk("lb wait mem_req", 32'(mem_req), 1);
        chk("lb wait wb", 32'(wb_valid), 0);
        mem_ack = 1'b1; mem_rdata = 32'h8000_0000;
        @(negedge clk) mem_ack = 1'b0;
        chk("lb wb_valid", 32'(wb_valid), 1);
        chk("lb wb_rd", 32'(wb_rd), 9);
        chk("lb wb_data", wb_data, 32'hFFFF_FF80);
        chk("lb ex_ready", 32'(ex_ready), 1);

        // LBU zero-wait: wb two cycles after accept
        issue(OP_L, LBU_func3, 32'h203, 32'd0, 5'd10);
        @(negedge clk) ex_valid = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk) mem_ack = 1'b0;
        chk("lbu wb_valid", 32'(wb_valid), 1);
        chk("lbu wb_data", wb_data, 32'h0000_0080);
        @(negedge clk);
        chk("lbu wb single", 32'(wb_valid), 0);

        // LH upper halfword sign-extended
        issue(OP_L, LH_func3, 32'h302, 32'd0, 5'd11);
        @(negedge clk) ex_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h9ABC_1234;
        @(negedge clk) mem_ack = 1'b0;
        chk("lh wb_data", wb_data, 32'hFFFF_9ABC);

        // misaligned LW
        issue(OP_L, LW_func3, 32'h102, 32'd0, 5'd4);
        @(negedge clk) ex_valid = 1'b0;
        chk("lw misalign", 32'(misalign), 1);
        chk("lw mis mem_req", 32'(mem_req), 0);
        chk("lw mis ex_ready", 32'(ex_ready), 1);
        chk("lw mis wb", 32'(wb_valid), 0);
        @(negedge clk);
        chk("lw misalign pulse", 32'(misalign), 0);

        // SW timeout, bounded loop
        issue(OP_S, SW_func3, 32'h400, 32'hCAFE_F00D, 5'd2);
        @(negedge clk) ex_valid = 1'b0;
        chk("sw mem_wstrb", 32'(mem_wstrb), 32'hF);
        chk("sw mem_wdata", mem_wdata, 32'hCAFE_F00D);
        n = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            n++;
            chk("sw no bus_err", 32'(bus_err), 0);
            @(negedge clk);
        end
        chk("sw req cycles", n, 16);
        chk("sw bus_err", 32'(bus_err), 1);
        chk("sw req dropped", 32'(mem_req), 0);
        chk("sw to wb", 32'(wb_valid), 0);
        issue(OP_I, 3'd0, 32'h77, 32'd0, 5'd5);
        @(negedge clk) ex_valid = 1'b0;
        chk("post-to bus_err", 32'(bus_err), 0);
        chk("post-to wb_valid", 32'(wb_valid), 1);
        chk("post-to wb_data", wb_data, 32'h77);

        // reset mid-access
        issue(OP_L, LW_func3, 32'h500, 32'd0, 5'd6);
        @(negedge clk) ex_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst mem_req", 32'(mem_req), 0);
        chk("arst ex_ready", 32'(ex_ready), 1);
        chk("arst mem_addr", 32'(mem_addr), 0);
        chk("arst wb_data", wb_data, 0);
        @(negedge clk) rst_n = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("arst ack ignored", 32'(wb_valid), 0);
        @(negedge clk) mem_ack = 1'b0;
        chk("arst no wb", 32'(wb_valid), 0);
        chk("arst no bus_err", 32'(bus_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
